// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, event packing and FSM state type for the PS/2 event receiver
package ps2_pkg;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int EV_W = 10;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_BRK_BIT = 8;
    localparam int EV_EXT_BIT = 9;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    function automatic logic [EV_W-1:0] mk_event(input logic ext, input logic brk, input logic [7:0] code);
        logic [EV_W-1:0] ev;
        ev = '0;
        ev[EV_EXT_BIT] = ext;
        ev[EV_BRK_BIT] = brk;
        ev[EV_CODE_LSB +: 8] = code;
        return ev;
    endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: show-ahead event FIFO with push-on-full-with-pop and drop-on-full rules
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0] r_wr, r_rd;
    logic w_pop, w_push;
    assign o_level = r_wr - r_rd;
    assign o_empty = r_wr == r_rd;
    assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);
    assign o_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop) r_rd <= r_rd + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/ps2_event_rx.sv
// ps2_event_rx: filtered PS/2 frame receiver with watchdog, prefix folding and an event FIFO
module ps2_event_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TIMEOUT_US  = 200,
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int FOLD_PREFIX = 1,
    parameter int ERR_W       = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    output logic [EV_W-1:0]               ev_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [ERR_W-1:0]              err_count,
    output logic [ERR_W-1:0]              ovf_count
);
    localparam longint TO_CYC = longint'(TIMEOUT_US) * longint'(CLK_HZ) / 1000000;
    localparam int WD_W = $clog2(TO_CYC + 1);
    localparam int FC_W = $clog2(FILTER_LEN + 1);
    logic [1:0] r_s0, r_s1, r_flt;
    logic [FC_W-1:0] r_fcnt [2];
    logic r_clk_d;
    ps2_state_t r_state, w_state_nx;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic r_par, r_ext, r_brk, r_push;
    logic [EV_W-1:0] r_push_data;
    logic [WD_W-1:0] r_wd;
    logic [ERR_W-1:0] r_err, r_ovf;
    logic w_fall, w_dat, w_timeout, w_stop, w_good, w_err;
    logic w_is_ext, w_is_brk, w_full, w_empty, w_pop, w_ovf;
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_s0 <= '1;
            r_s1 <= '1;
            r_flt <= '1;
            r_clk_d <= 1'b1;
            for (int k = 0; k < 2; k++) r_fcnt[k] <= '0;
        end else begin
            r_s0 <= {PS2_DAT, PS2_CLK};
            r_s1 <= r_s0;
            r_clk_d <= r_flt[0];
            for (int k = 0; k < 2; k++) begin
                if (r_s1[k] == r_flt[k]) begin
                    r_fcnt[k] <= '0;
                end else if (r_fcnt[k] == FC_W'(FILTER_LEN - 1)) begin
                    r_flt[k] <= r_s1[k];
                    r_fcnt[k] <= '0;
                end else begin
                    r_fcnt[k] <= r_fcnt[k] + FC_W'(1);
                end
            end
        end
    end
    assign w_fall = r_clk_d & ~r_flt[0];
    assign w_dat = r_flt[1];
    assign w_timeout = (r_state != IDLE) & ~w_fall & (r_wd == WD_W'(TO_CYC - 1));
    assign w_stop = w_fall & (r_state == STOP);
    assign w_good = w_stop & w_dat & (^{r_shift, r_par});
    assign w_err = (w_fall & (r_state == IDLE) & w_dat) | (w_stop & ~w_good) | w_timeout;
    assign w_is_ext = (FOLD_PREFIX != 0) && (r_shift == PS2_EXT);
    assign w_is_brk = (FOLD_PREFIX != 0) && (r_shift == PS2_BRK);
    assign w_pop = ev_ready & ev_valid;
    assign w_ovf = r_push & w_full & ~w_pop;
    always_comb begin
        w_state_nx = r_state;
        if (w_timeout) begin
            w_state_nx = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    w_state_nx = w_dat ? IDLE : DATA;
                DATA:    w_state_nx = (r_idx == 3'd7) ? PARITY : DATA;
                PARITY:  w_state_nx = STOP;
                default: w_state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_shift <= '0;
            r_par <= 1'b0;
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            r_push <= 1'b0;
            r_push_data <= '0;
            r_wd <= '0;
            r_err <= '0;
            r_ovf <= '0;
        end else begin
            r_state <= w_state_nx;
            r_push <= w_good & ~w_is_ext & ~w_is_brk;
            r_wd <= (w_fall || r_state == IDLE) ? '0 : r_wd + WD_W'(1);
            if (w_fall && r_state == IDLE) r_idx <= '0;
            if (w_fall && r_state == DATA) begin
                r_shift <= {w_dat, r_shift[7:1]};
                r_idx <= r_idx + 3'd1;
            end
            if (w_fall && r_state == PARITY) r_par <= w_dat;
            if (w_good) r_push_data <= mk_event(r_ext, r_brk, r_shift);
            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_good) begin
                r_ext <= w_is_ext | (w_is_brk & r_ext);
                r_brk <= w_is_brk | (w_is_ext & r_brk);
            end
            if (w_err && r_err != '1) r_err <= r_err + ERR_W'(1);
            if (w_ovf && r_ovf != '1) r_ovf <= r_ovf + ERR_W'(1);
        end
    end
    ps2_event_fifo #(.WIDTH(EV_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (ev_data),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );
    assign ev_valid = ~w_empty;
    assign err_count = r_err;
    assign ovf_count = r_ovf;
endmodule

// File: tb/tb_ps2_event_rx.sv
// tb_ps2_event_rx: directed PS/2 frame vectors against folded and raw receiver instances
module tb_ps2_event_rx;
    localparam int HALF = 10;
    localparam int GAP = 30;
    localparam int LAT = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic ev_ready = 1'b0;
    logic ev_ready_raw = 1'b0;
    logic [9:0] ev_data, ev_data_raw;
    logic ev_valid, ev_valid_raw;
    logic [3:0] fifo_level, fifo_level_raw;
    logic [7:0] err_count, err_raw, ovf_count, ovf_raw;
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    ps2_event_rx #(.CLK_HZ(1000000), .TIMEOUT_US(200), .FILTER_LEN(4), .FIFO_DEPTH(8),
                   .FOLD_PREFIX(1), .ERR_W(8)) dut (
        .CLOCK_50(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .fifo_level(fifo_level), .err_count(err_count), .ovf_count(ovf_count));
    ps2_event_rx #(.CLK_HZ(1000000), .TIMEOUT_US(200), .FILTER_LEN(4), .FIFO_DEPTH(8),
                   .FOLD_PREFIX(0), .ERR_W(8)) dut_raw (
        .CLOCK_50(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .ev_data(ev_data_raw), .ev_valid(ev_valid_raw), .ev_ready(ev_ready_raw),
        .fifo_level(fifo_level_raw), .err_count(err_raw), .ovf_count(ovf_raw));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask
    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop_v, input int mode);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ flip);
        ps2_dat = stop_v;
        tick(HALF);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            tick(LAT - 1);
            check("lat_before", ev_valid, 0);
            tick(1);
            check("lat_at", ev_valid, 1);
            tick(HALF - LAT);
        end else if (mode == 2) begin
            tick(LAT - 1);
            ev_ready = 1'b1;
            tick(1);
            ev_ready = 1'b0;
            tick(HALF - LAT);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(GAP);
    endtask
    task automatic pop(input string tag, input logic [9:0] exp, input logic raw);
        if (raw) begin
            check(tag, ev_data_raw, exp);
            ev_ready_raw = 1'b1;
        end else begin
            check(tag, ev_data, exp);
            ev_ready = 1'b1;
        end
        tick(1);
        ev_ready = 1'b0;
        ev_ready_raw = 1'b0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        ev_ready = 1'b0;
        ev_ready_raw = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        tick(3);
        check("rst_valid", ev_valid, 0);
        check("rst_data", ev_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_err", err_count, 0);
        check("rst_ovf", ovf_count, 0);
        reset = 1'b0;
        tick(2);
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        check("t1_data", ev_data, 10'h01C);
        check("t1_level", fifo_level, 1);
        check("t1_err", err_count, 0);
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b1, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h75, 1'b0, 1'b1, 0);
        check("t2_fold_level", fifo_level, 1);
        check("t2_fold_data", ev_data, 10'h375);
        check("t2_raw_level", fifo_level_raw, 3);
        check("t2_raw_err", err_raw, 0);
        check("t2_raw_ovf", ovf_raw, 0);
        pop("t2_raw0", 10'h0E0, 1'b1);
        pop("t2_raw1", 10'h0F0, 1'b1);
        pop("t2_raw2", 10'h075, 1'b1);
        check("t2_raw_empty", ev_valid_raw, 0);
        do_reset();
        send_frame(8'h29, 1'b1, 1'b1, 0);
        check("t3_par_valid", ev_valid, 0);
        check("t3_par_err", err_count, 1);
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        send_frame(8'h6B, 1'b0, 1'b1, 0);
        check("t3_level", fifo_level, 1);
        check("t3_data", ev_data, 10'h06B);
        check("t3_err", err_count, 2);
        do_reset();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_dat = 1'b1;
        tick(300);
        check("t4_to_err", err_count, 1);
        check("t4_to_valid", ev_valid, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        check("t4_data", ev_data, 10'h05A);
        check("t4_err", err_count, 1);
        do_reset();
        for (int i = 0; i < 10; i++) send_frame(8'(8'h15 + i), 1'b0, 1'b1, 0);
        check("t5_level", fifo_level, 8);
        check("t5_ovf", ovf_count, 2);
        check("t5_head", ev_data, 10'h015);
        send_frame(8'h2A, 1'b0, 1'b1, 2);
        check("t5_pp_level", fifo_level, 8);
        check("t5_pp_ovf", ovf_count, 2);
        for (int i = 1; i < 8; i++) pop("t5_pop", 10'(10'h015 + i), 1'b0);
        pop("t5_pop_last", 10'h02A, 1'b0);
        check("t5_empty", fifo_level, 0);
        do_reset();
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(10);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(10);
        ps2_dat = 1'b0;
        tick(10);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(10);
        ps2_dat = 1'b1;
        tick(300);
        check("t6_glitch_err", err_count, 0);
        check("t6_glitch_level", fifo_level, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check("t6_after_glitch", ev_data, 10'h01C);
        send_frame(8'h29, 1'b1, 1'b1, 0);
        check("t6_pre_err", err_count, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        tick(1);
        check("t6_rst_valid", ev_valid, 0);
        check("t6_rst_data", ev_data, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_err", err_count, 0);
        check("t6_rst_ovf", ovf_count, 0);
        reset = 1'b0;
        ps2_dat = 1'b1;
        tick(GAP);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check("t6_post_data", ev_data, 10'h01C);
        check("t6_post_level", fifo_level, 1);
        check("t6_post_err", err_count, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
